// File: rtl/cpu_pkg.sv
// Shared constants and the fetch FSM state type for the core front end.
package cpu_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam int PC_STEP = 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts consecutive un-acked fetch cycles and flags expiry.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expire
);
  logic [15:0] r_count;

  // Expiry fires on the TIMEOUT_CYCLES-th waiting cycle; an ack that same cycle wins.
  assign o_expire = i_active && !i_ack && (r_count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_active || i_ack) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem over req/ack, holds the word until commit.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               commit,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               fetch_err,
  output fetch_state_e       state_dbg
);
  // imem handshake: imem_req stays high with imem_addr stable until a cycle
  // where imem_ack=1 is seen on the rising edge; that edge transfers imem_rdata.

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic               r_run;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               w_fetching;
  logic               w_expire;
  logic [ADDR_W-1:0]  w_pc_even;

  // r_run holds req low for the first cycle after reset release.
  assign w_fetching = r_run && (r_state == S_FETCH);
  assign w_pc_even  = next_pc & ~{{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FETCH_TIMEOUT_EN
  logic r_fetch_err;

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_fetching),
    .i_ack    (imem_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_err <= 1'b0;
    end else if (w_expire) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_expire  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_fetching && imem_ack) w_next_state = S_VALID;
        else if (w_expire)          w_next_state = S_HALT;
      end
      S_VALID: begin
        if (commit) w_next_state = halt ? S_HALT : S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
      if (w_fetching && imem_ack) r_instr <= imem_rdata;
      if (r_state == S_VALID && commit && !halt) r_pc <= w_pc_even;
    end
  end

  assign imem_req    = w_fetching;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_VALID);
  assign halted      = (r_state == S_HALT);
  assign state_dbg   = r_state;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed fetch/commit/halt/reset sequences,
// with a scoreboard of expected {pc, instr} pairs checked whenever instr_valid rises.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] next_pc;
  logic        commit;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        fetch_err;
  fetch_state_e state_dbg;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .commit      (commit),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each rising instr_valid must match the oldest expected fetch.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc_instr", {pc, instr}, e);
      end
    end
    prev_valid = instr_valid;
  end

  // Waits (bounded) for req, holds ack off for 'delay' cycles, then returns 'data'.
  task automatic fetch_resp(input int delay, input logic [15:0] data, input logic [15:0] addr);
    int k;
    k = 0;
    while (!imem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", 32'(imem_addr), 32'(addr));
      if (i == 1) begin
        commit  = 1'b1;
        next_pc = 16'h7776;
      end else begin
        commit = 1'b0;
      end
      @(negedge clk);
    end
    commit = 1'b0;
    check("ack_addr", 32'(imem_addr), 32'(addr));
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back({addr, data});
    @(negedge clk);
    imem_ack = 1'b0;
    check("valid_after_ack", 32'(instr_valid), 32'd1);
    check("req_low_in_valid", 32'(imem_req), 32'd0);
  endtask

  task automatic do_commit(input logic [15:0] npc, input logic h, input logic [15:0] exp_pc);
    commit  = 1'b1;
    halt    = h;
    next_pc = npc;
    @(negedge clk);
    commit = 1'b0;
    halt   = 1'b0;
    check("commit_pc", 32'(pc), 32'(exp_pc));
    if (!h) begin
      check("commit_req", 32'(imem_req), 32'd1);
      check("commit_addr", 32'(imem_addr), 32'(exp_pc));
      check("commit_valid", 32'(instr_valid), 32'd0);
    end else begin
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; next_pc = '0; commit = 1'b0; halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_FETCH));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'h0000);
    fetch_resp(0, 16'hA123, 16'h0000);

    do_commit(16'h0042, 1'b0, 16'h0042);
    fetch_resp(3, 16'h1111, 16'h0042);
    // Stray ack while holding a word must not overwrite it.
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stray_ack_instr", 32'(instr), 32'h1111);
    check("stray_ack_valid", 32'(instr_valid), 32'd1);

    do_commit(16'h0043, 1'b0, 16'h0042);
    fetch_resp(0, 16'h2222, 16'h0042);
    do_commit(16'hFFFF, 1'b0, 16'hFFFE);
    fetch_resp(2, 16'h3333, 16'hFFFE);
    do_commit(16'h0000, 1'b0, 16'h0000);
    fetch_resp(0, 16'h4444, 16'h0000);
    do_commit(16'h0011, 1'b0, 16'h0010);
    fetch_resp(1, 16'h5555, 16'h0010);
    do_commit(16'h0020, 1'b1, 16'h0010);

    for (int i = 0; i < 22; i++) begin
      commit  = (i % 4 == 1);
      imem_ack = (i % 5 == 2);
      imem_rdata = 16'hBEEF;
      next_pc = 16'h0300;
      @(negedge clk);
      check("halt_req_low", 32'(imem_req), 32'd0);
    end
    commit = 1'b0; imem_ack = 1'b0;
    check("halt_pc_hold", 32'(pc), 32'h0010);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_instr_hold", 32'(instr), 32'h5555);

    // Reset out of halt, then reset mid-fetch at 0x0042.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rehalt_clear", 32'(halted), 32'd0);
    fetch_resp(0, 16'h6666, 16'h0000);
    do_commit(16'h0042, 1'b0, 16'h0042);
    rst_n = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h9999;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_pc_reset", 32'(pc), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'h0000);
    check("restart_instr", 32'(instr), 32'h0000);
    check("restart_valid", 32'(instr_valid), 32'd0);
    fetch_resp(0, 16'h7777, 16'h0000);
    do_commit(16'h0100, 1'b0, 16'h0100);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("to_pre_req", 32'(imem_req), 32'd1);
    check("to_pre_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_req_low", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    fetch_resp(15, 16'h8888, 16'h0000);
    check("to_ack_wins_err", 32'(fetch_err), 32'd0);
    check("to_ack_wins_halt", 32'(halted), 32'd0);
`else
    for (int i = 0; i < 30; i++) @(negedge clk);
    check("nowd_req", 32'(imem_req), 32'd1);
    check("nowd_addr", 32'(imem_addr), 32'h0100);
    check("nowd_err", 32'(fetch_err), 32'd0);
    check("nowd_halted", 32'(halted), 32'd0);
    fetch_resp(0, 16'h8888, 16'h0100);
`endif

    @(negedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural PC register and consumes the next-PC value produced by the branch/PC-calculation logic.
- Issues instruction-memory reads over a req/ack handshake and captures the returned word.
- Holds the word valid for decode until the core commits, then loads the new PC.
- Sits between the PC-calculation logic and decode; terminates on HLT.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction word width
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)
- TIMEOUT_CYCLES, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- next_pc  in  ADDR_W  next PC from PC-calculation logic, sampled on commit
- commit  in  1  current instruction retires; load next_pc
- halt  in  1  current instruction is HLT; sampled with commit
- imem_req  out  1  instruction-memory read request
- imem_addr  out  ADDR_W  read address, equal to pc
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  INSTR_W  read data
- pc  out  ADDR_W  current PC
- instr  out  INSTR_W  captured instruction
- instr_valid  out  1  instr holds a fetched, uncommitted word
- halted  out  1  core stopped
- fetch_err  out  1  watchdog expiry; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=S_FETCH, pc=RESET_PC, instr=0, instr_valid=0, halted=0, fetch_err=0. imem_req rises one cycle after rst_n deasserts (state register leaves reset, then a Moore output).
- FSM states:
  - S_FETCH: imem_req=1, imem_addr=pc. On a clk edge with imem_ack=1, capture instr<=imem_rdata and go to S_VALID. Otherwise stay; req and addr stay stable until ack.
  - S_VALID: instr_valid=1, imem_req=0.
    - On commit=1, halt=0: pc<=next_pc with bit 0 forced to 0, go to S_FETCH.
    - On commit=1, halt=1: pc unchanged, go to S_HALT.
  - S_HALT: halted=1, imem_req=0, instr_valid=0. Exit only via reset.
- Outputs are Moore (registered state decode). No combinational path from imem_ack or commit to any output.
- Latency: ack edge -> instr_valid high next cycle. Commit edge -> imem_req high next cycle with the new address. Minimum 2 cycles per instruction with zero-wait memory (ack in the same cycle as req).
- Boundary conditions:
  - imem_ack outside S_FETCH: ignored, instr unchanged.
  - commit or halt outside S_VALID: ignored, pc unchanged.
  - next_pc arithmetic is not done here. PC wraps naturally if next_pc wraps (16'hFFFE -> 16'h0000 is supplied externally).
  - Odd next_pc: bit 0 is dropped silently.
  - Reset mid-fetch: imem_req drops asynchronously. An ack arriving during reset is discarded.
  - Reset in S_VALID or S_HALT: returns to S_FETCH at RESET_PC.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to S_FETCH and increments each S_FETCH cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: set fetch_err=1 (sticky until reset), go to S_HALT, drop imem_req.
  - An ack on the expiry cycle wins: normal capture, no error.
- Undefined: no counter; S_FETCH waits indefinitely; fetch_err tied 0.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, RESET_PC
  - PC_STEP=2
  - fetch state enum {S_FETCH, S_VALID, S_HALT}
- One sub-module, fetch_watchdog: counter plus expiry compare, instantiated only under FETCH_TIMEOUT_EN.
- FSM, pc register and instr register stay in fetch_unit.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), rdata=16'hA123 -> imem_addr=16'h0000 in the first req cycle; instr_valid=1, instr=16'hA123 next cycle.
- In S_VALID, commit=1, next_pc=16'h0042 -> next cycle pc=16'h0042, imem_req=1, instr_valid=0. Also drive next_pc=16'h0043 -> pc=16'h0042.
- Ack delayed 3 cycles -> imem_addr stays stable and imem_req stays high for all 3 cycles; instr_valid rises exactly one cycle after ack. A stray ack in S_VALID leaves instr unchanged.
- Commit with halt=1 at pc=16'h0010 -> halted=1, pc stays 16'h0010, imem_req stays 0 for 20+ cycles; further commit pulses have no effect.
- Assert rst_n=0 mid-fetch at pc=16'h0042 -> imem_req=0 immediately; after release, fetch restarts at 16'h0000.
- With FETCH_TIMEOUT_EN and no ack for 16 cycles -> fetch_err=1, halted=1. Repeat with ack on cycle 16 -> normal capture, fetch_err=0.
